// File: rtl/axi_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_master
// Purpose  : Single-outstanding AXI-lite style master bridging a simple
//            command/response port to AW/W/B and AR/R channels, with timeout.
// Revision : 1.0
// ============================================================================
module axi_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic                  write_valid,
    input  logic                  write_ready,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_data_valid,
    input  logic                  write_data_ready,
    input  logic [DATA_WIDTH-1:0] write_response,
    input  logic                  write_response_valid,
    output logic                  write_response_ready,
    output logic [ADDR_WIDTH-1:0] read_address,
    output logic                  read_valid,
    input  logic                  read_ready,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic [DATA_WIDTH-1:0] read_response,
    input  logic                  read_response_valid,
    output logic                  read_response_ready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Timeout fires on the edge that would bring the counter to TIMEOUT,
    // i.e. after TIMEOUT full cycles spent in one waiting state.
    localparam logic [15:0] c_WAIT_LIMIT = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_n;
    logic [15:0] r_wait_cnt;
    logic        w_accept;
    logic        w_timeout;
    logic        w_waiting;
    logic        w_aw_done;
    logic        w_w_done;

    always_comb begin
        w_state_n = r_state;
        w_accept  = (r_state == S_IDLE) && cmd_valid && cmd_ready;
        w_timeout = (r_wait_cnt == c_WAIT_LIMIT);
        w_waiting = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                    (r_state == S_RD_REQ) || (r_state == S_RD_RESP);
        // A channel counts as done once its valid has dropped or it handshakes now
        w_aw_done = !write_valid || write_ready;
        w_w_done  = !write_data_valid || write_data_ready;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_n = cmd_write ? S_WR_REQ : S_RD_REQ;
            end
            S_WR_REQ: begin
                if (w_aw_done && w_w_done) w_state_n = S_WR_RESP;
                else if (w_timeout)        w_state_n = S_DONE;
            end
            S_WR_RESP: begin
                if (write_response_valid || w_timeout) w_state_n = S_DONE;
            end
            S_RD_REQ: begin
                if (read_ready)     w_state_n = S_RD_RESP;
                else if (w_timeout) w_state_n = S_DONE;
            end
            S_RD_RESP: begin
                if (read_response_valid || w_timeout) w_state_n = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 16'd0;
        end else begin
            r_state <= w_state_n;
            if (w_state_n != r_state || !w_waiting) r_wait_cnt <= 16'd0;
            else                                    r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_ready            <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_rdata            <= '0;
            rsp_error            <= 1'b0;
            write_address        <= '0;
            write_valid          <= 1'b0;
            write_data           <= '0;
            write_data_valid     <= 1'b0;
            write_response_ready <= 1'b0;
            read_address         <= '0;
            read_valid           <= 1'b0;
            read_response_ready  <= 1'b0;
        end else begin
            cmd_ready            <= (w_state_n == S_IDLE);
            rsp_valid            <= (w_state_n == S_DONE);
            write_response_ready <= (w_state_n == S_WR_RESP);
            read_valid           <= (w_state_n == S_RD_REQ);
            read_response_ready  <= (w_state_n == S_RD_RESP);

            if (w_accept && cmd_write) begin
                write_address    <= cmd_address;
                write_data       <= cmd_wdata;
                write_valid      <= 1'b1;
                write_data_valid <= 1'b1;
            end
            if (w_accept && !cmd_write) read_address <= cmd_address;

            // Each write channel drops independently on its own handshake
            if (r_state == S_WR_REQ) begin
                if (write_ready || w_state_n != S_WR_REQ)      write_valid      <= 1'b0;
                if (write_data_ready || w_state_n != S_WR_REQ) write_data_valid <= 1'b0;
            end

            if (r_state == S_WR_RESP && write_response_valid) begin
                rsp_rdata <= '0;
                rsp_error <= |write_response;
            end else if (r_state == S_RD_RESP && read_response_valid) begin
                rsp_rdata <= read_data;
                rsp_error <= |read_response;
            end else if (w_waiting && w_state_n == S_DONE) begin
                rsp_rdata <= '0;
                rsp_error <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_master
// Purpose  : Directed self-checking bench for axi_master (TIMEOUT = 8).
// Revision : 1.0
// ============================================================================
module tb_axi_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_address = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] write_address;
    logic        write_valid;
    logic        write_ready = 1'b0;
    logic [31:0] write_data;
    logic        write_data_valid;
    logic        write_data_ready = 1'b0;
    logic [31:0] write_response = '0;
    logic        write_response_valid = 1'b0;
    logic        write_response_ready;
    logic [31:0] read_address;
    logic        read_valid;
    logic        read_ready = 1'b0;
    logic [31:0] read_data = '0;
    logic [31:0] read_response = '0;
    logic        read_response_valid = 1'b0;
    logic        read_response_ready;

    int total = 0;
    int bad   = 0;

    axi_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .write_address(write_address), .write_valid(write_valid), .write_ready(write_ready),
        .write_data(write_data), .write_data_valid(write_data_valid),
        .write_data_ready(write_data_ready),
        .write_response(write_response), .write_response_valid(write_response_valid),
        .write_response_ready(write_response_ready),
        .read_address(read_address), .read_valid(read_valid), .read_ready(read_ready),
        .read_data(read_data), .read_response(read_response),
        .read_response_valid(read_response_valid), .read_response_ready(read_response_ready)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values while reset is held
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_valids", 32'({write_valid, write_data_valid, read_valid}), 32'd0);
        chk("rst_readies", 32'({write_response_ready, read_response_ready}), 32'd0);
        chk("rst_addr", write_address | read_address | write_data | rsp_rdata, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("cmd_ready_after_release", 32'(cmd_ready), 32'd1);

        // Write, slave always ready: AW/W at N+1, B at N+2, rsp at N+3
        write_ready = 1'b1; write_data_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 32'd10; cmd_wdata = 32'd1234;
        tick();
        cmd_valid = 1'b0;
        chk("wr_aw_valid", 32'(write_valid), 32'd1);
        chk("wr_w_valid", 32'(write_data_valid), 32'd1);
        chk("wr_addr", write_address, 32'd10);
        chk("wr_data", write_data, 32'd1234);
        chk("wr_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        tick();
        chk("wr_valids_cleared", 32'({write_valid, write_data_valid}), 32'd0);
        chk("wr_bready", 32'(write_response_ready), 32'd1);
        write_response_valid = 1'b1; write_response = 32'd0;
        tick();
        write_response_valid = 1'b0;
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_error", 32'(rsp_error), 32'd0);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("wr_bready_drop", 32'(write_response_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_back_idle_rsp", 32'(rsp_valid), 32'd0);
        chk("wr_back_idle_ready", 32'(cmd_ready), 32'd1);
        write_ready = 1'b0; write_data_ready = 1'b0;

        // Read back 1234
        read_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'd10;
        tick();
        cmd_valid = 1'b0;
        chk("rd_ar_valid", 32'(read_valid), 32'd1);
        chk("rd_addr", read_address, 32'd10);
        tick();
        read_ready = 1'b0;
        chk("rd_ar_drop", 32'(read_valid), 32'd0);
        chk("rd_rready", 32'(read_response_ready), 32'd1);
        read_response_valid = 1'b1; read_data = 32'd1234; read_response = 32'd0;
        tick();
        read_response_valid = 1'b0;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", rsp_rdata, 32'd1234);
        chk("rd_rsp_error", 32'(rsp_error), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Skewed write: W ready in first valid cycle, AW ready in third
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 32'd20; cmd_wdata = 32'hABCD;
        tick();
        cmd_valid = 1'b0;
        write_data_ready = 1'b1;
        chk("skew_n1_valids", 32'({write_valid, write_data_valid}), 32'b11);
        tick();
        write_data_ready = 1'b0;
        chk("skew_n2_w_drop", 32'({write_valid, write_data_valid}), 32'b10);
        chk("skew_n2_no_resp", 32'(write_response_ready), 32'd0);
        tick();
        write_ready = 1'b1;
        chk("skew_n3_aw_held", 32'(write_valid), 32'd1);
        chk("skew_n3_addr_stable", write_address, 32'd20);
        chk("skew_n3_no_resp", 32'(write_response_ready), 32'd0);
        tick();
        write_ready = 1'b0;
        chk("skew_n4_aw_drop", 32'(write_valid), 32'd0);
        chk("skew_n4_bready", 32'(write_response_ready), 32'd1);
        write_response_valid = 1'b1; write_response = 32'd0;
        tick();
        write_response_valid = 1'b0;
        chk("skew_rsp", 32'({rsp_valid, rsp_error}), 32'b10);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Error read response, rsp held with rsp_ready low; stray R valid ignored
        read_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'd40;
        tick();
        cmd_valid = 1'b0;
        tick();
        read_ready = 1'b0;
        read_response_valid = 1'b1; read_data = 32'h55; read_response = 32'd2;
        tick();
        read_data = 32'h77; read_response = 32'd0;
        for (int i = 0; i < 4; i++) begin
            chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("err_rsp_error", 32'(rsp_error), 32'd1);
            chk("err_rsp_rdata", rsp_rdata, 32'h55);
            tick();
        end
        read_response_valid = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 32'd50;
        tick();
        rsp_ready = 1'b0;
        chk("done_release_idle", 32'(cmd_ready), 32'd1);
        chk("done_no_same_cycle_accept", 32'(write_valid), 32'd0);
        cmd_valid = 1'b0;
        tick();

        // Timeout: AR never accepted
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'h30;
        tick();
        cmd_valid = 1'b0;
        chk("to_ar_valid_first", 32'(read_valid), 32'd1);
        repeat (7) tick();
        chk("to_ar_valid_last", 32'(read_valid), 32'd1);
        chk("to_no_rsp_yet", 32'(rsp_valid), 32'd0);
        tick();
        chk("to_ar_drop", 32'(read_valid), 32'd0);
        chk("to_rsp", 32'({rsp_valid, rsp_error}), 32'b11);
        chk("to_rdata", rsp_rdata, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset asserted while in WR_RESP
        write_ready = 1'b1; write_data_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 32'd60; cmd_wdata = 32'd7;
        tick();
        cmd_valid = 1'b0;
        tick();
        write_ready = 1'b0; write_data_ready = 1'b0;
        chk("mid_in_wr_resp", 32'(write_response_ready), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_bready_cleared", 32'(write_response_ready), 32'd0);
        chk("mid_outputs_zero", write_address | write_data, 32'd0);
        chk("mid_no_rsp", 32'({rsp_valid, cmd_ready}), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("mid_after_release", 32'({rsp_valid, cmd_ready}), 32'b01);
        read_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'd10;
        tick();
        cmd_valid = 1'b0;
        chk("post_rst_ar", 32'(read_valid), 32'd1);
        tick();
        read_ready = 1'b0;
        read_response_valid = 1'b1; read_data = 32'd99; read_response = 32'd0;
        tick();
        read_response_valid = 1'b0;
        chk("post_rst_rsp", 32'({rsp_valid, rsp_error}), 32'b10);
        chk("post_rst_rdata", rsp_rdata, 32'd99);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
